// File: rtl/dac_axis_pkg.sv
// Shared widths and the playback state enumeration for the DAC AXI-stream sink.
// Latency: n/a (package). Backpressure: n/a.
// Contents: sample/beat widths, underrun counter width, state_t.
package dac_axis_pkg;

  localparam int SAMPLE_W       = 16;
  localparam int BEAT_W         = 64;
  localparam int UNDERRUN_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_PLAY  = 2'd2
  } state_t;

endpackage

// File: rtl/dac_beat_fifo.sv
// Single-clock beat buffer holding {last, half, data} per entry, head visible combinationally.
// Latency: a pushed beat is at the head the cycle after the push edge.
// Backpressure: caller must not push when full; push at full / pop at empty are ignored.
// Ports: clk, rst_n (async low), flush (sync empty), push/push_*, pop, head_*, count, empty, full.
module dac_beat_fifo #(
  parameter int DEPTH = 8,
  parameter int DW    = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [DW-1:0]            push_data,
  input  logic                     push_last,
  input  logic                     push_half,
  input  logic                     pop,
  output logic [DW-1:0]            head_data,
  output logic                     head_last,
  output logic                     head_half,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);

  logic [DW+1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  assign {head_last, head_half, head_data} = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= {push_last, push_half, push_data};
  end

endmodule

// File: rtl/dac_data_axis_sink.sv
// AXI-stream sink that buffers I/Q beats and plays one registered sample per cycle to a DAC.
// Latency: first sample is valid the cycle after PLAY is entered; PRIME waits for PRIME_LEVEL beats or a tlast.
// Backpressure: s_axis_tready drops when the beat FIFO is full or abort is high.
// Ports: aclk/aresetn; s_axis_* slave; dac_enable/abort/clear_status control;
//        dac_data_i/q/valid, frame_start/done pulses, sticky underrun + counter, sample_count, busy.
module dac_data_axis_sink
  import dac_axis_pkg::*;
#(
  parameter int DAC_AXI_DATA_WIDTH = BEAT_W,
  parameter int FIFO_DEPTH         = 8,
  parameter int PRIME_LEVEL        = 4
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic [DAC_AXI_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                            s_axis_tvalid,
  input  logic                            s_axis_tlast,
  input  logic [DAC_AXI_DATA_WIDTH/8-1:0] s_axis_tkeep,
  output logic                            s_axis_tready,
  input  logic                            dac_enable,
  input  logic                            abort,
  input  logic                            clear_status,
  output logic [SAMPLE_W-1:0]             dac_data_i,
  output logic [SAMPLE_W-1:0]             dac_data_q,
  output logic                            dac_data_valid,
  output logic                            frame_start,
  output logic                            frame_done,
  output logic                            underrun,
  output logic [UNDERRUN_CNT_W-1:0]       underrun_count,
  output logic [31:0]                     sample_count,
  output logic                            busy
);

  localparam int KW = DAC_AXI_DATA_WIDTH / 8;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] PRIME_LVL = CW'(PRIME_LEVEL);

  state_t                        state, state_nxt;
  logic                          pos, pos_nxt;      // 0: low sample of head beat, 1: high sample
  logic                          in_frame;          // a sample of the current frame has been played
  logic                          ready_en;          // holds tready low until the first edge after reset
  logic [CW-1:0]                 last_cnt;          // stored beats carrying tlast
  logic                          push, pop, half;
  logic [DAC_AXI_DATA_WIDTH-1:0] head_data;
  logic                          head_last, head_half;
  logic [CW-1:0]                 fifo_count;
  logic                          fifo_empty, fifo_full;
  logic [SAMPLE_W-1:0]           smp_i, smp_q;
  logic                          smp_vld, smp_fs, smp_fd, urun;
  logic                          unused_keep;

  assign s_axis_tready = ready_en && !fifo_full && !abort;
  assign push          = s_axis_tvalid && s_axis_tready;
  // Only the upper half enables of the closing beat matter; all other tkeep bits are ignored.
  assign half          = s_axis_tlast && (s_axis_tkeep[KW-1:KW/2] == '0);
  assign unused_keep   = &{1'b0, s_axis_tkeep[KW/2-1:0]};
  assign busy          = (state != ST_IDLE);

  dac_beat_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (DAC_AXI_DATA_WIDTH)
  ) u_fifo (
    .clk       (aclk),
    .rst_n     (aresetn),
    .flush     (abort),
    .push      (push),
    .push_data (s_axis_tdata),
    .push_last (s_axis_tlast),
    .push_half (half),
    .pop       (pop),
    .head_data (head_data),
    .head_last (head_last),
    .head_half (head_half),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  always_comb begin
    state_nxt = state;
    pos_nxt   = pos;
    pop       = 1'b0;
    smp_vld   = 1'b0;
    smp_i     = '0;
    smp_q     = '0;
    smp_fs    = 1'b0;
    smp_fd    = 1'b0;
    urun      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!fifo_empty) state_nxt = ST_PRIME;
      end
      ST_PRIME: begin
        if (fifo_count >= PRIME_LVL || last_cnt != '0) state_nxt = ST_PLAY;
      end
      ST_PLAY: begin
        if (dac_enable) begin
          if (fifo_empty) begin
            // Still inside a frame with nothing buffered: emit a hole and count it.
            urun = 1'b1;
          end else begin
            smp_vld = 1'b1;
            smp_fs  = !in_frame;
            if (pos) begin
              smp_i = head_data[3*SAMPLE_W +: SAMPLE_W];
              smp_q = head_data[2*SAMPLE_W +: SAMPLE_W];
            end else begin
              smp_i = head_data[SAMPLE_W +: SAMPLE_W];
              smp_q = head_data[0 +: SAMPLE_W];
            end
            if (pos || head_half) begin
              pop     = 1'b1;
              pos_nxt = 1'b0;
              if (head_last) begin
                smp_fd = 1'b1;
                // Head is leaving; anything else stored or arriving now starts the next prime.
                state_nxt = (fifo_count != CW'(1) || push) ? ST_PRIME : ST_IDLE;
              end
            end else begin
              pos_nxt = 1'b1;
            end
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (abort) begin
      state_nxt = ST_IDLE;
      pos_nxt   = 1'b0;
      pop       = 1'b0;
      smp_vld   = 1'b0;
      smp_i     = '0;
      smp_q     = '0;
      smp_fs    = 1'b0;
      smp_fd    = 1'b0;
      urun      = 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state          <= ST_IDLE;
      pos            <= 1'b0;
      in_frame       <= 1'b0;
      ready_en       <= 1'b0;
      last_cnt       <= '0;
      dac_data_i     <= '0;
      dac_data_q     <= '0;
      dac_data_valid <= 1'b0;
      frame_start    <= 1'b0;
      frame_done     <= 1'b0;
      underrun       <= 1'b0;
      underrun_count <= '0;
      sample_count   <= '0;
    end else begin
      state          <= state_nxt;
      pos            <= pos_nxt;
      ready_en       <= 1'b1;
      dac_data_i     <= smp_i;
      dac_data_q     <= smp_q;
      dac_data_valid <= smp_vld;
      frame_start    <= smp_fs;
      frame_done     <= smp_fd;

      if (abort || smp_fd) in_frame <= 1'b0;
      else if (smp_vld)    in_frame <= 1'b1;

      if (abort) begin
        last_cnt <= '0;
      end else begin
        unique case ({push && s_axis_tlast, pop && head_last})
          2'b10:   last_cnt <= last_cnt + 1'b1;
          2'b01:   last_cnt <= last_cnt - 1'b1;
          default: last_cnt <= last_cnt;
        endcase
      end

      if (smp_vld) sample_count <= smp_fs ? 32'd1 : sample_count + 32'd1;

      // A new underrun beats a simultaneous clear: the flag stays set and this cycle is counted.
      if (urun) begin
        underrun <= 1'b1;
        if (clear_status)
          underrun_count <= UNDERRUN_CNT_W'(1);
        else if (underrun_count != {UNDERRUN_CNT_W{1'b1}})
          underrun_count <= underrun_count + 1'b1;
      end else if (clear_status) begin
        underrun       <= 1'b0;
        underrun_count <= '0;
      end
    end
  end

endmodule
